// File: rtl/asic_pwrseq.sv
// asic_pwrseq: power-domain switch sequencer for one switchable core domain.
// Staggers enables to N header-switch groups to limit inrush, then releases
// isolation and finally domain reset. Power-down runs the same steps in reverse.
//
// Ports:
//   clk          always-on clock
//   reset        asynchronous active-high reset
//   pwr_req      1 = domain requested on, 0 = off
//   step_cycles  extra cycles between group enables/disables (quasi-static)
//   sw_ack       per-group power-good acks (already synchronized)
//   sw_en        per-group switch enables (cumulative)
//   iso_en       1 = domain outputs isolated
//   dom_reset    1 = domain held in reset
//   pwr_good     domain fully on and out of reset
//   busy         sequence in progress (not OFF, ON or ERR)
//   error        sticky ack-timeout flag
module asic_pwrseq #(
  parameter int unsigned N       = 4,
  parameter int unsigned CW      = 8,
  parameter int unsigned RSTDLY  = 3,
  parameter int unsigned TIMEOUT = 64,
  parameter              PROP    = "DEFAULT"
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pwr_req,
  input  logic [CW-1:0] step_cycles,
  input  logic [N-1:0]  sw_ack,
  output logic [N-1:0]  sw_en,
  output logic          iso_en,
  output logic          dom_reset,
  output logic          pwr_good,
  output logic          busy,
  output logic          error
);

  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned RW = (RSTDLY > 1) ? $clog2(RSTDLY) : 1;
  localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit ParamOk = (N >= 1) && (RSTDLY >= 1) && ($bits(PROP) > 0);

  // Elaboration-time parameter sanity check.
  if (!ParamOk) begin : g_bad_param
    $error("asic_pwrseq: N and RSTDLY must be >= 1");
  end

  typedef enum logic [2:0] {
    S_OFF, S_UP, S_ISO, S_ON, S_DN_RST, S_DN_ISO, S_DN, S_ERR
  } state_t;

  state_t         state, state_n;
  logic [KW-1:0]  k, k_n;          // current switch group
  logic [CW-1:0]  cnt, cnt_n;      // step delay
  logic [RW-1:0]  rcnt, rcnt_n;    // isolation-to-reset delay
  logic [WW-1:0]  wcnt, wcnt_n;    // ack wait
  logic [N-1:0]   sw_en_n;
  logic           iso_en_n, dom_reset_n, pwr_good_n, busy_n, error_n;

  // Next-state, counters and next registered outputs.
  always_comb begin
    state_n = state;
    k_n     = k;
    cnt_n   = cnt;
    rcnt_n  = rcnt;
    wcnt_n  = wcnt;
    sw_en_n = sw_en;
    error_n = error;

    case (state)
      S_OFF: begin
        if (pwr_req) begin
          state_n = S_UP;
          k_n     = '0;
          cnt_n   = step_cycles;
          wcnt_n  = '0;
          sw_en_n = N'(1);
          error_n = 1'b0;
        end
      end
      S_UP: begin
        if (!pwr_req) begin
          // Abort: ramp down from the current group; iso/reset never released.
          state_n    = S_DN;
          sw_en_n[k] = 1'b0;
          cnt_n      = step_cycles;
        end else if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else if (sw_ack[k]) begin
          wcnt_n = '0;
          if (k == KW'(N - 1)) begin
            state_n = S_ISO;
            rcnt_n  = RW'(RSTDLY - 1);
          end else begin
            k_n          = k + KW'(1);
            sw_en_n[k_n] = 1'b1;
            cnt_n        = step_cycles;
          end
        end else if ((TIMEOUT != 0) && (wcnt == WW'(TIMEOUT - 1))) begin
          state_n = S_ERR;
          sw_en_n = '0;
          error_n = 1'b1;
        end else begin
          wcnt_n = wcnt + WW'(1);
        end
      end
      S_ISO: begin
        if (!pwr_req) begin
          state_n = S_DN_ISO;
        end else if (rcnt != '0) begin
          rcnt_n = rcnt - RW'(1);
        end else begin
          state_n = S_ON;
        end
      end
      S_ON: begin
        if (!pwr_req) state_n = S_DN_RST;
      end
      S_DN_RST: state_n = S_DN_ISO;
      S_DN_ISO: begin
        state_n    = S_DN;
        sw_en_n[k] = 1'b0;
        cnt_n      = step_cycles;
      end
      S_DN: begin
        // k is the group cleared most recently; group 0 cleared -> OFF.
        if (k == '0) begin
          state_n = S_OFF;
        end else if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else begin
          k_n          = k - KW'(1);
          sw_en_n[k_n] = 1'b0;
          cnt_n        = step_cycles;
        end
      end
      S_ERR: begin
        if (!pwr_req) state_n = S_OFF;
      end
      default: begin
        state_n = S_OFF;
        sw_en_n = '0;
      end
    endcase

    // Moore outputs decoded from the next state so they register with it.
    iso_en_n    = !(state_n inside {S_ISO, S_ON, S_DN_RST});
    dom_reset_n = (state_n != S_ON);
    pwr_good_n  = (state_n == S_ON);
    busy_n      = state_n inside {S_UP, S_ISO, S_DN_RST, S_DN_ISO, S_DN};
  end

  // State, counters and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_OFF;
      k         <= '0;
      cnt       <= '0;
      rcnt      <= '0;
      wcnt      <= '0;
      sw_en     <= '0;
      iso_en    <= 1'b1;
      dom_reset <= 1'b1;
      pwr_good  <= 1'b0;
      busy      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_n;
      k         <= k_n;
      cnt       <= cnt_n;
      rcnt      <= rcnt_n;
      wcnt      <= wcnt_n;
      sw_en     <= sw_en_n;
      iso_en    <= iso_en_n;
      dom_reset <= dom_reset_n;
      pwr_good  <= pwr_good_n;
      busy      <= busy_n;
      error     <= error_n;
    end
  end

endmodule
